// File: rtl/wiggle_pkg.sv
// wiggle_pkg: shared constants and types for the LED wiggle demo block.
//   WIGGLE_CNT_W / WIGGLE_GPIO_W / WIGGLE_TICK_BITS : default parameter values
//   dir_e : bounce direction (DIR_UP towards MSB, DIR_DOWN towards LSB)
package wiggle_pkg;

  localparam int unsigned WIGGLE_CNT_W     = 27;
  localparam int unsigned WIGGLE_GPIO_W    = 8;
  localparam int unsigned WIGGLE_TICK_BITS = 24;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/wiggle_bounce.sv
// wiggle_bounce: knight-rider bounce of a single lit bit, one step per tick.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst   : synchronous active-high reset (pos=0, dir=up, pattern bit 0)
//   i_tick  : advance the bounce by one position on this edge
//   o_gpio  : registered one-hot pattern of the current position
module wiggle_bounce
  import wiggle_pkg::*;
#(
  parameter int unsigned GPIO_W = WIGGLE_GPIO_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_tick,
  output logic [GPIO_W-1:0] o_gpio
);

  localparam int unsigned       POS_W   = $clog2(GPIO_W);
  localparam logic [POS_W-1:0]  POS_MAX = POS_W'(GPIO_W - 1);

  logic [POS_W-1:0]  r_pos, w_pos_next;
  dir_e              r_dir, w_dir_next;
  logic [GPIO_W-1:0] r_gpio, w_gpio_next;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pos  <= '0;
      r_dir  <= DIR_UP;
      r_gpio <= GPIO_W'(1);
    end else begin
      r_pos  <= w_pos_next;
      r_dir  <= w_dir_next;
      r_gpio <= w_gpio_next;
    end
  end

  always_comb begin
    w_pos_next = r_pos;
    w_dir_next = r_dir;
    if (i_tick) begin
      unique case (r_dir)
        DIR_UP: begin
          if (r_pos == POS_MAX) begin
            w_dir_next = DIR_DOWN;
            w_pos_next = POS_MAX - 1'b1;
          end else begin
            w_pos_next = r_pos + 1'b1;
          end
        end
        DIR_DOWN: begin
          if (r_pos == '0) begin
            w_dir_next = DIR_UP;
            w_pos_next = POS_W'(1);
          end else begin
            w_pos_next = r_pos - 1'b1;
          end
        end
      endcase
    end
    // Decode from the next position so the pattern lands on the same edge as pos.
    w_gpio_next = GPIO_W'(1) << w_pos_next;
  end

  assign o_gpio = r_gpio;

endmodule

// File: rtl/wiggle.sv
// wiggle: LED wiggle demo for board bring-up.
// Free-running counter plus a bouncing single-LED pattern stepped by a
// prescaler tick taken from the low counter bits.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst   : synchronous active-high reset
//   o_gpio  : LED pattern (one-hot, active-high by default)
//   o_count : free-running counter, straight from the register
// Build option: define WIGGLE_ACTIVE_LOW_EN to invert o_gpio for active-low LEDs.
module wiggle
  import wiggle_pkg::*;
#(
  parameter int unsigned CNT_W     = WIGGLE_CNT_W,
  parameter int unsigned GPIO_W    = WIGGLE_GPIO_W,
  parameter int unsigned TICK_BITS = WIGGLE_TICK_BITS
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic [GPIO_W-1:0] o_gpio,
  output logic [CNT_W-1:0]  o_count
);

  logic [CNT_W-1:0]  r_count;
  logic              w_tick;
  logic [GPIO_W-1:0] w_gpio_oh;

  // Wraps silently at 2^CNT_W-1.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  // Fires on the cycle before the low bits roll over.
  assign w_tick = &r_count[TICK_BITS-1:0];

  wiggle_bounce #(
    .GPIO_W(GPIO_W)
  ) u_bounce (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_tick(w_tick),
    .o_gpio(w_gpio_oh)
  );

`ifdef WIGGLE_ACTIVE_LOW_EN
  assign o_gpio = ~w_gpio_oh;
`else
  assign o_gpio = w_gpio_oh;
`endif

  assign o_count = r_count;

endmodule

// File: tb/tb_wiggle.sv
// tb_wiggle: randomized-reset scoreboard bench for wiggle.
// Two instances: the main one (CNT_W=27, TICK_BITS=2) and a small one
// (CNT_W=4, TICK_BITS=4) that exercises counter wrap.
module tb_wiggle;

  localparam int G   = 8;
  localparam int CW0 = 27;
  localparam int TB0 = 2;
  localparam int CW1 = 4;
  localparam int TB1 = 4;
  localparam int NCYC = 3000;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [G-1:0]   gpio0, gpio1;
  logic [CW0-1:0] cnt0;
  logic [CW1-1:0] cnt1;

  wiggle #(.CNT_W(CW0), .GPIO_W(G), .TICK_BITS(TB0)) u_dut0 (
    .i_clk  (clk),
    .i_rst  (rst),
    .o_gpio (gpio0),
    .o_count(cnt0)
  );

  wiggle #(.CNT_W(CW1), .GPIO_W(G), .TICK_BITS(TB1)) u_dut1 (
    .i_clk  (clk),
    .i_rst  (rst),
    .o_gpio (gpio1),
    .o_count(cnt1)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint       c0;
    longint       c1;
    logic [G-1:0] g0;
    logic [G-1:0] g1;
  } exp_t;

  exp_t   q[$];
  int     total = 0;
  int     bad = 0;
  bit     started = 1'b0;
  longint m_cnt[2];
  int     m_k[2];  // ticks seen since reset

  // LED pattern after k ticks: triangle walk over 0..G-1 with period 2*(G-1).
  function automatic logic [G-1:0] pat(input int k);
    int p, pos;
    logic [G-1:0] v;
    p = k % (2 * (G - 1));
    pos = (p < G) ? p : 2 * (G - 1) - p;
    v = '0;
    v[pos] = 1'b1;
`ifdef WIGGLE_ACTIVE_LOW_EN
    v = ~v;
`endif
    return v;
  endfunction

  task automatic step_model(input bit r);
    for (int i = 0; i < 2; i++) begin
      longint tmod = (i == 0) ? (64'd1 << TB0) : (64'd1 << TB1);
      longint cmod = (i == 0) ? (64'd1 << CW0) : (64'd1 << CW1);
      if (r) begin
        m_cnt[i] = 0;
        m_k[i]   = 0;
      end else begin
        if ((m_cnt[i] % tmod) == tmod - 1) m_k[i]++;
        m_cnt[i] = (m_cnt[i] + 1) % cmod;
      end
    end
  endtask

  // Applies rst for the next rising edge and queues the state expected after it.
  task automatic drive(input bit r);
    exp_t e;
    @(negedge clk);
    rst = r;
    step_model(r);
    e.c0 = m_cnt[0];
    e.c1 = m_cnt[1];
    e.g0 = pat(m_k[0]);
    e.g1 = pat(m_k[1]);
    q.push_back(e);
    started = 1'b1;
  endtask

  // Monitor: every cycle the DUT presents new outputs; compare against the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        if (started) begin
          total++;
          bad++;
          $display("FAIL queue_underflow at %0t: got no expectation, need one", $time);
        end
      end else begin
        e = q.pop_front();
        total++;
        if (longint'(cnt0) != e.c0) begin
          bad++;
          $display("FAIL count0 at %0t: got %0d need %0d", $time, cnt0, e.c0);
        end
        total++;
        if (gpio0 !== e.g0) begin
          bad++;
          $display("FAIL gpio0 at %0t: got %b need %b", $time, gpio0, e.g0);
        end
        total++;
        if (longint'(cnt1) != e.c1) begin
          bad++;
          $display("FAIL count1 at %0t: got %0d need %0d", $time, cnt1, e.c1);
        end
        total++;
        if (gpio1 !== e.g1) begin
          bad++;
          $display("FAIL gpio1 at %0t: got %b need %b", $time, gpio1, e.g1);
        end
      end
    end
  end

  initial begin
    bit r;
    bit mid_done = 1'b0;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    m_k[0] = 0;
    m_k[1] = 0;
    drive(1'b1);
    drive(1'b1);
    for (int n = 0; n < NCYC; n++) begin
      // k==9 means the LED sits at bit 5 heading down: reset there once on purpose.
      if (!mid_done && m_k[0] == 9) begin
        r = 1'b1;
        mid_done = 1'b1;
      end else begin
        r = ($urandom_range(0, 299) == 0);
      end
      drive(r);
    end
    @(posedge clk);
    #2;
    started = 1'b0;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, need 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
